uart_bus_bridge: RTL and testbench

UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

---
 rtl/uart_bus_bridge_if.sv | 21 ++
 rtl/uart_bus_bridge.sv | 214 +++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_bridge_if.sv
// Bus-side signal bundle between the UART bridge (master) and the downstream
// dot-matrix register block (slave).
interface uart_bus_bridge_if;
   logic       CS;
   logic       Write;
   logic       Read;
   logic [7:0] Address;
   logic [7:0] Data_o;
   logic [3:0] STRB;
   logic       ack;

   modport master (
      output CS, Write, Read, Address, Data_o, STRB,
      input  ack
   );

   modport slave (
      input  CS, Write, Read, Address, Data_o, STRB,
      output ack
   );
endinterface

// File: rtl/uart_bus_bridge.sv
// UART-to-bus bridge: frames of A5 <addr> <data> become single-byte bus writes.
// Optional UBB_CHECKSUM_EN adds a trailing byte that must equal addr ^ data.
module uart_bus_bridge #(
   parameter int BAUD_DIV    = 434,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic               mclock,
   input  logic               mreset,
   input  logic               uart_rx,
   uart_bus_bridge_if.master  bus,
   output logic               busy,
   output logic               err
);
   localparam int BW = $clog2(BAUD_DIV + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [BW-1:0] L_HALF_END = BW'(BAUD_DIV / 2 - 1);
   localparam logic [BW-1:0] L_BIT_END  = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] L_BAUD_ONE = BW'(1);
   localparam logic [TW-1:0] L_TO_END   = TW'(ACK_TIMEOUT - 1);
   localparam logic [TW-1:0] L_TO_ONE   = TW'(1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
`ifdef UBB_CHECKSUM_EN
   typedef enum logic [1:0] {P_SYNC, P_ADDR, P_DATA, P_CSUM} p_state_t;
`else
   typedef enum logic [1:0] {P_SYNC, P_ADDR, P_DATA} p_state_t;
`endif
   typedef enum logic [1:0] {B_IDLE, B_REQ, B_WAIT} b_state_t;

   logic            r_rx_meta, r_rx_sync, r_rx_prev;
   rx_state_t       r_rstate;
   logic [BW-1:0]   r_baud_cnt;
   logic [2:0]      r_bit_cnt;
   logic [7:0]      r_shift;
   logic            r_byte_valid, r_stop_err;
   p_state_t        r_pstate;
   logic [7:0]      r_addr_buf, r_data_buf;
   logic            r_frame_done, r_perr;
   b_state_t        r_bstate;
   logic [TW-1:0]   r_to_cnt;
   logic            r_cs, r_write, r_busy, r_err;
   logic [7:0]      r_addr, r_data;
   logic [3:0]      r_strb;
   logic [BW-1:0]   w_baud_inc;
   logic [TW-1:0]   w_to_inc;

   assign w_baud_inc = (r_baud_cnt == '1) ? r_baud_cnt : r_baud_cnt + L_BAUD_ONE;
   assign w_to_inc   = (r_to_cnt == '1)   ? r_to_cnt   : r_to_cnt + L_TO_ONE;

   assign bus.CS      = r_cs;
   assign bus.Write   = r_write;
   assign bus.Read    = 1'b0;
   assign bus.Address = r_addr;
   assign bus.Data_o  = r_data;
   assign bus.STRB    = r_strb;
   assign busy        = r_busy;
   assign err         = r_err;

   // Two-flop synchronizer plus a delayed copy for falling-edge detection
   always_ff @(posedge mclock or negedge mreset) begin
      if (!mreset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= uart_rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   // UART receiver: start re-check at half a bit, then one sample per bit period
   always_ff @(posedge mclock or negedge mreset) begin
      if (!mreset) begin
         r_rstate     <= R_IDLE;
         r_baud_cnt   <= '0;
         r_bit_cnt    <= 3'd0;
         r_shift      <= 8'h00;
         r_byte_valid <= 1'b0;
         r_stop_err   <= 1'b0;
      end else begin
         r_byte_valid <= 1'b0;
         r_stop_err   <= 1'b0;
         case (r_rstate)
            R_IDLE: begin
               r_baud_cnt <= '0;
               r_bit_cnt  <= 3'd0;
               if (r_rx_prev && !r_rx_sync) r_rstate <= R_START;
            end
            R_START: begin
               if (r_baud_cnt == L_HALF_END) begin
                  r_baud_cnt <= '0;
                  r_rstate   <= r_rx_sync ? R_IDLE : R_DATA;
               end else begin
                  r_baud_cnt <= w_baud_inc;
               end
            end
            R_DATA: begin
               if (r_baud_cnt == L_BIT_END) begin
                  r_baud_cnt <= '0;
                  r_shift    <= {r_rx_sync, r_shift[7:1]};
                  if (r_bit_cnt == 3'd7) r_rstate  <= R_STOP;
                  else                   r_bit_cnt <= r_bit_cnt + 3'd1;
               end else begin
                  r_baud_cnt <= w_baud_inc;
               end
            end
            R_STOP: begin
               if (r_baud_cnt == L_BIT_END) begin
                  r_rstate <= R_IDLE;
                  if (r_rx_sync) r_byte_valid <= 1'b1;
                  else           r_stop_err   <= 1'b1;
               end else begin
                  r_baud_cnt <= w_baud_inc;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   // Frame parser; a framing error resynchronises on the next A5
   always_ff @(posedge mclock or negedge mreset) begin
      if (!mreset) begin
         r_pstate     <= P_SYNC;
         r_addr_buf   <= 8'h00;
         r_data_buf   <= 8'h00;
         r_frame_done <= 1'b0;
         r_perr       <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_perr       <= 1'b0;
         if (r_stop_err) begin
            r_perr   <= 1'b1;
            r_pstate <= P_SYNC;
         end else if (r_byte_valid) begin
            case (r_pstate)
               P_SYNC: if (r_shift == 8'hA5) r_pstate <= P_ADDR;
               P_ADDR: begin
                  r_addr_buf <= r_shift;
                  r_pstate   <= P_DATA;
               end
`ifdef UBB_CHECKSUM_EN
               P_DATA: begin
                  r_data_buf <= r_shift;
                  r_pstate   <= P_CSUM;
               end
               P_CSUM: begin
                  if (r_shift == (r_addr_buf ^ r_data_buf)) r_frame_done <= 1'b1;
                  else                                      r_perr       <= 1'b1;
                  r_pstate <= P_SYNC;
               end
`else
               P_DATA: begin
                  r_data_buf   <= r_shift;
                  r_frame_done <= 1'b1;
                  r_pstate     <= P_SYNC;
               end
`endif
               default: r_pstate <= P_SYNC;
            endcase
         end
      end
   end

   // Bus master: one write per frame, ended by ack or by the timeout
   always_ff @(posedge mclock or negedge mreset) begin
      if (!mreset) begin
         r_bstate <= B_IDLE;
         r_to_cnt <= '0;
         r_cs     <= 1'b0;
         r_write  <= 1'b0;
         r_addr   <= 8'h00;
         r_data   <= 8'h00;
         r_strb   <= 4'b0000;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_err <= r_perr;
         case (r_bstate)
            B_IDLE: begin
               if (r_frame_done) begin
                  r_cs     <= 1'b1;
                  r_write  <= 1'b1;
                  r_strb   <= 4'b0001;
                  r_addr   <= r_addr_buf;
                  r_data   <= r_data_buf;
                  r_busy   <= 1'b1;
                  r_to_cnt <= '0;
                  r_bstate <= B_REQ;
               end
            end
            B_REQ, B_WAIT: begin
               // A frame arriving mid-transaction is dropped, never queued
               if (r_frame_done) r_err <= 1'b1;
               if (bus.ack || (r_to_cnt == L_TO_END)) begin
                  if (!bus.ack) r_err <= 1'b1;
                  r_cs     <= 1'b0;
                  r_write  <= 1'b0;
                  r_strb   <= 4'b0000;
                  r_addr   <= 8'h00;
                  r_data   <= 8'h00;
                  r_busy   <= 1'b0;
                  r_bstate <= B_IDLE;
               end else begin
                  r_to_cnt <= w_to_inc;
                  r_bstate <= B_WAIT;
               end
            end
            default: r_bstate <= B_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge (BAUD_DIV=4, ACK_TIMEOUT=8).
module tb_uart_bus_bridge;
   localparam int BD = 4;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      int         len;
   } exp_t;

   logic mclock = 1'b0;
   logic mreset = 1'b0;
   logic uart_rx = 1'b1;
   logic busy, err;
   int   ack_mode = 1;
   int   n_checks = 0;
   int   n_fail = 0;
   int   err_cnt = 0;
   int   exp_err = 0;
   exp_t exp_q[$];

   uart_bus_bridge_if bus_if ();

   uart_bus_bridge #(.BAUD_DIV(BD), .ACK_TIMEOUT(8)) dut (
      .mclock (mclock),
      .mreset (mreset),
      .uart_rx(uart_rx),
      .bus    (bus_if.master),
      .busy   (busy),
      .err    (err)
   );

   always #5 mclock = ~mclock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge mclock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      wait_clk(BD);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         wait_clk(BD);
      end
      uart_rx = stop_bit;
      wait_clk(BD);
      uart_rx = 1'b1;
      wait_clk(2 * BD);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] d);
      send_byte(8'hA5, 1'b1);
      send_byte(a, 1'b1);
      send_byte(d, 1'b1);
`ifdef UBB_CHECKSUM_EN
      send_byte(a ^ d, 1'b1);
`endif
   endtask

   task automatic expect_write(input logic [7:0] a, input logic [7:0] d, input int len);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.len  = len;
      exp_q.push_back(e);
   endtask

   task automatic checkpoint(input string name);
      wait_clk(40);
      chk({name, "_err_count"}, 64'(err_cnt), 64'(exp_err));
      chk({name, "_writes_pending"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Ack responder: raises ack two cycles after CS rises when ack_mode is 1
   initial begin
      int cs_age = 0;
      bus_if.ack = 1'b0;
      forever begin
         @(posedge mclock);
         #1;
         if (bus_if.CS) cs_age++;
         else           cs_age = 0;
         bus_if.ack = (ack_mode == 1) && bus_if.CS && (cs_age == 3);
      end
   end

   // Monitor: pops the scoreboard on each CS rise and checks the transaction shape
   initial begin
      logic cs_prev = 1'b0;
      logic active  = 1'b0;
      int   cs_len  = 0;
      int   cur_len = 0;
      exp_t e;
      forever begin
         @(negedge mclock);
         if (!mreset) begin
            cs_prev = 1'b0;
            active  = 1'b0;
            cs_len  = 0;
         end else begin
            if (err) err_cnt++;
            if (bus_if.CS && !cs_prev) begin
               cs_len = 1;
               if (exp_q.size() == 0) begin
                  chk("unexpected_write", {48'd0, bus_if.Address, bus_if.Data_o}, 64'd0);
                  n_checks++;
                  n_fail++;
                  $display("FAIL no_write_expected addr=%0h data=%0h", bus_if.Address, bus_if.Data_o);
                  active = 1'b0;
               end else begin
                  e = exp_q.pop_front();
                  chk("write_fields",
                      {42'd0, busy, bus_if.Write, bus_if.Read, bus_if.STRB, bus_if.Address, bus_if.Data_o},
                      {42'd0, 1'b1, 1'b1, 1'b0, 4'b0001, e.addr, e.data});
                  cur_len = e.len;
                  active  = 1'b1;
               end
            end else if (bus_if.CS) begin
               cs_len++;
            end else if (cs_prev && active) begin
               chk("cs_high_cycles", 64'(cs_len), 64'(cur_len));
               chk("outputs_cleared",
                   {42'd0, busy, bus_if.Write, bus_if.Read, bus_if.STRB, bus_if.Address, bus_if.Data_o},
                   64'd0);
               active = 1'b0;
            end
            cs_prev = bus_if.CS;
         end
      end
   end

   initial begin
      int waited;
      wait_clk(3);
      chk("reset_outputs",
          {40'd0, bus_if.CS, bus_if.Write, bus_if.Read, busy, err, bus_if.STRB, bus_if.Address, bus_if.Data_o},
          64'd0);
      mreset = 1'b1;
      wait_clk(5);

      // Basic frame acked two cycles after CS
      expect_write(8'h03, 8'h5A, 3);
      send_frame(8'h03, 8'h5A);
      checkpoint("basic");

      // Leading junk before the sync byte
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h5A, 1'b1);
      expect_write(8'h01, 8'h02, 3);
      send_frame(8'h01, 8'h02);
      checkpoint("resync");

      // Framing error on the address byte, then a good frame
      send_byte(8'hA5, 1'b1);
      send_byte(8'h42, 1'b0);
      exp_err++;
      expect_write(8'h07, 8'hFF, 3);
      send_frame(8'h07, 8'hFF);
      checkpoint("stop_error");

      // Start glitch must not produce a byte
      uart_rx = 1'b0;
      wait_clk(1);
      uart_rx = 1'b1;
      wait_clk(20);
      expect_write(8'h5A, 8'hC3, 3);
      send_frame(8'h5A, 8'hC3);
      checkpoint("glitch");

      // Ack never arrives: CS held ACK_TIMEOUT cycles, then err
      ack_mode = 0;
      expect_write(8'h10, 8'h20, 8);
      send_frame(8'h10, 8'h20);
      exp_err++;
      checkpoint("timeout");

      // Reset mid-transaction drops outputs without a clock edge
      expect_write(8'h66, 8'h77, 0);
      send_frame(8'h66, 8'h77);
      waited = 0;
      while (!bus_if.CS && waited < 300) begin
         wait_clk(1);
         waited++;
      end
      chk("cs_seen_before_reset", 64'(bus_if.CS), 64'd1);
      wait_clk(2);
      #2;
      mreset = 1'b0;
      #1;
      chk("async_reset_drop", {61'd0, bus_if.CS, bus_if.Write, busy}, 64'd0);
      wait_clk(3);
      mreset = 1'b1;
      checkpoint("after_reset");

      ack_mode = 1;
      expect_write(8'hAB, 8'hCD, 3);
      send_frame(8'hAB, 8'hCD);
      checkpoint("post_reset_frame");

`ifdef UBB_CHECKSUM_EN
      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h5A, 1'b1);
      send_byte(8'h58, 1'b1);
      exp_err++;
      checkpoint("csum_bad");
      expect_write(8'h03, 8'h5A, 3);
      send_frame(8'h03, 8'h5A);
      checkpoint("csum_good");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
